// File: rtl/regfile_dump_if.sv
// Beat stream from the register dumper: one (index, value) pair per handshake.
interface regfile_dump_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [63:0] out_data;

  modport master (output out_valid, out_idx, out_data, input  out_ready);
  modport slave  (input  out_valid, out_idx, out_data, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Walks register indices 0..LAST_REG, captures each read value into a held beat,
// and keeps a running XOR of every accepted beat.
module regfile_dump #(
  parameter int LAST_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [4:0]            ra,
  input  logic [63:0]           rd,
  regfile_dump_if.master        beat,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           checksum
);

  localparam logic [4:0] LAST = LAST_REG[4:0];

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic        vld, vld_nxt;
  logic [4:0]  oidx, oidx_nxt;
  logic [63:0] odata, odata_nxt;
  logic [63:0] sum, sum_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      vld   <= 1'b0;
      oidx  <= '0;
      odata <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      vld   <= vld_nxt;
      oidx  <= oidx_nxt;
      odata <= odata_nxt;
      sum   <= sum_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    vld_nxt   = vld;
    oidx_nxt  = oidx;
    odata_nxt = odata;
    sum_nxt   = sum;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          sum_nxt   = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // rd is snapshotted here; later register-file writes cannot reach the beat
        odata_nxt = rd;
        oidx_nxt  = idx;
        vld_nxt   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (vld && beat.out_ready) begin
          sum_nxt = sum ^ odata;
          vld_nxt = 1'b0;
          if (idx == LAST) begin
            state_nxt = FIN;
          end else begin
            idx_nxt   = 5'(idx + 5'd1);
            state_nxt = FETCH;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ra             = idx;
  assign beat.out_valid = vld;
  assign beat.out_idx   = oidx;
  assign beat.out_data  = odata;
  assign busy           = (state != IDLE);
  assign done           = (state == FIN);
  assign checksum       = sum;

  a_idx_bound: assert property (@(posedge clk) disable iff (reset) idx <= LAST);
  a_hold: assert property (@(posedge clk) disable iff (reset)
    (beat.out_valid && !beat.out_ready) |=>
      (beat.out_valid && $stable(beat.out_idx) && $stable(beat.out_data)));

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboarded bench: expected beats/checksums queued at start, popped by a monitor.
module tb_regfile_dump;
  localparam int LAST = 31;

  logic        clk = 1'b0;
  logic        reset, start, start_b;
  logic [4:0]  ra, ra_b;
  logic [63:0] rd, rd_b;
  logic        busy, done, busy_b, done_b;
  logic [63:0] checksum, checksum_b;
  logic [63:0] mem [32];

  regfile_dump_if bus ();
  regfile_dump_if bus_b ();

  regfile_dump #(.LAST_REG(LAST)) dut (
    .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd), .beat(bus),
    .busy(busy), .done(done), .checksum(checksum));

  regfile_dump #(.LAST_REG(30)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ra(ra_b), .rd(rd_b), .beat(bus_b),
    .busy(busy_b), .done(done_b), .checksum(checksum_b));

  always #5 clk = ~clk;
  assign rd   = mem[ra];
  assign rd_b = 64'(ra_b);

  typedef struct packed { logic [4:0] idx; logic [63:0] data; } beat_t;
  beat_t       beat_q[$];
  logic [63:0] sum_q[$];
  logic [63:0] last_sum = '0;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
  int beats_b = 0, dones_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // monitor: every accepted beat and every done pulse is checked against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (beat_q.size() == 0) timeout("unexpected_beat");
        else begin
          beat_t e;
          e = beat_q.pop_front();
          chk("beat_idx", 64'(bus.out_idx), 64'(e.idx));
          chk("beat_data", bus.out_data, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (sum_q.size() == 0) timeout("unexpected_done");
        else chk("checksum", checksum, sum_q.pop_front());
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        chk("b_idx", 64'(bus_b.out_idx), 64'(beats_b));
        chk("b_data", bus_b.out_data, 64'(beats_b));
        beats_b++;
      end
      if (done_b) dones_b++;
    end
  end

  // reference model: a dump returns the register file contents as seen at start
  task automatic issue_start();
    logic [63:0] s;
    beat_t b;
    s = '0;
    for (int i = 0; i <= LAST; i++) begin
      b.idx  = 5'(i);
      b.data = mem[i];
      beat_q.push_back(b);
      s ^= mem[i];
    end
    sum_q.push_back(s);
    last_sum = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input bit rnd);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      if (done_cnt > d0) begin
        bus.out_ready = 1'b1;
        return;
      end
    end
    bus.out_ready = 1'b1;
    timeout("wait_done");
  endtask

  task automatic wait_beat(input int n);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid && bus.out_idx == 5'(n)) return;
    end
    timeout("wait_beat");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [63:0] hd;
    reset = 1'b1; start = 1'b0; start_b = 1'b0;
    bus.out_ready = 1'b1; bus_b.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 64'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", checksum, 64'd0);
    chk("rst_ra", 64'(ra), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // full dump, ready held high: 32 beats, checksum 0, inclusive latency 2*(N)+1
    d0 = done_cnt;
    issue_start();
    wait_done(1'b0);
    chk("dump_cycles", 64'(done_cyc - start_cyc + 1), 64'(2 * (LAST + 1) + 1));
    chk("one_done", 64'(done_cnt - d0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("sum_hold", checksum, last_sum);
    chk("idle_busy", 64'(busy), 64'd0);

    // backpressure on beat 7 for five cycles
    issue_start();
    wait_beat(7);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_idx", 64'(bus.out_idx), 64'd7);
      chk("stall_data", bus.out_data, 64'd7);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_done(1'b0);

    // register write right after beat 3 is captured must not reach that beat
    issue_start();
    wait_beat(3);
    mem[3] = 64'hDEAD;
    wait_done(1'b0);
    issue_start();
    wait_done(1'b0);
    mem[3] = 64'd3;

    // start during busy is dropped
    d0 = done_cnt;
    issue_start();
    wait_beat(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("busy_start_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_start_q", 64'(beat_q.size()), 64'd0);

    // start sampled in the done cycle is dropped
    issue_start();
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("fin_start_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end

    // randomized contents with random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
      issue_start();
      wait_done(1'b1);
      chk("rand_sum_hold", checksum, last_sum);
    end

    // reset during SEND of beat 12 aborts silently
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom} | 64'd1;
    issue_start();
    wait_beat(12);
    reset = 1'b1;
    beat_q.delete();
    sum_q.delete();
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", checksum, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    // LAST_REG=30 instance with Xi=i
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 0; k < 300 && dones_b == 0; k++) begin
      @(posedge clk); #1;
    end
    if (dones_b == 0) timeout("b_done");
    chk("b_sum", checksum_b, 64'd31);
    repeat (5) @(posedge clk);
    #1;
    chk("b_beats", 64'(beats_b), 64'd31);
    chk("b_dones", 64'(dones_b), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
